// File: rtl/fir_param_filter.sv
// Parameterised FIR filter with one time-shared multiplier (IDLE -> MAC -> OUT).
// Define FIR_SATURATE_EN to clamp out-of-range results; otherwise the result wraps.
module fir_param_filter #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 8,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]        coef_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic                     busy
);

  localparam int AW     = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + AW;
  localparam int EXT_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  localparam logic [AW:0] TAPS_K = (AW+1)'(TAPS);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                    state, state_next;
  logic signed [DATA_W-1:0]  x [TAPS];
  logic signed [COEF_W-1:0]  c [TAPS];
  logic signed [PROD_W-1:0]  prod, tap_prod;
  logic signed [ACC_W-1:0]   acc, acc_sum, shifted;
  logic signed [EXT_W-1:0]   ext;
  logic signed [OUT_W-1:0]   reduced;
  logic [AW:0]               k;
  logic [AW-1:0]             k_idx;
  logic                      take, coef_ok;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == OUT);

  assign take    = (state == IDLE) && in_valid;
  assign coef_ok = (state == IDLE) && coef_we && ({1'b0, coef_addr} < TAPS_K);
  assign k_idx   = k[AW-1:0];

  // Product is registered, so the MAC phase runs TAPS+1 cycles: cycle k
  // multiplies tap k while adding the product of tap k-1.
  always_comb begin
    // NOTE: default first so no path through this block infers a latch.
    tap_prod = '0;
    if (k < TAPS_K) tap_prod = PROD_W'(x[k_idx]) * PROD_W'(c[k_idx]);
  end

  assign acc_sum = acc + ACC_W'(prod);
  assign shifted = acc_sum >>> SHIFT;
  assign ext     = EXT_W'(shifted);

`ifdef FIR_SATURATE_EN
  always_comb begin
    reduced = ext[OUT_W-1:0];
    if (ext[EXT_W-1:OUT_W-1] != {(EXT_W-OUT_W+1){ext[EXT_W-1]}})
      reduced = ext[EXT_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  end
`else
  logic unused_ext;
  assign reduced    = ext[OUT_W-1:0];
  assign unused_ext = ^ext;
`endif

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid)      state_next = MAC;
      MAC:     if (k == TAPS_K)   state_next = OUT;
      OUT:     if (out_ready)     state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: delay line and coefficients are flops, not RAM, so they can be
      // reset; the filter must come up as an identity (c[0]=1) with zero history.
      for (int i = 0; i < TAPS; i++) begin
        x[i] <= '0;
        c[i] <= '0;
      end
      c[0]     <= COEF_W'(1);
      acc      <= '0;
      prod     <= '0;
      k        <= '0;
      out_data <= '0;
    end else begin
      if (coef_ok) c[coef_addr] <= coef_data;
      if (take) begin
        // NOTE: non-blocking, so each tap takes its neighbour's pre-edge value.
        for (int i = TAPS-1; i > 0; i--) x[i] <= x[i-1];
        x[0] <= in_data;
        acc  <= '0;
        prod <= '0;
        k    <= '0;
      end
      if (state == MAC) begin
        acc  <= acc_sum;
        prod <= tap_prod;
        k    <= k + 1'b1;
        if (k == TAPS_K) out_data <= reduced;
      end
    end
  end

endmodule

// File: tb/tb_fir_param_filter.sv
// Self-checking bench for fir_param_filter: directed cases with literal results plus
// randomized traffic checked against a dot-product model kept in the bench.
module tb_fir_param_filter;

  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int TAPS   = 8;
  localparam int OUT_W  = 16;
  localparam int SHIFT  = 0;
  localparam int AW     = $clog2(TAPS);
`ifdef FIR_SATURATE_EN
  localparam int BIG_RESULT = 32767;
`else
  localparam int BIG_RESULT = -2040;   // 129032 - 2*65536
`endif

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data = '0;
  logic                    coef_we = 1'b0;
  logic [AW-1:0]           coef_addr = '0;
  logic [COEF_W-1:0]       coef_data = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic signed [OUT_W-1:0] out_data;
  logic                    busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit rnd_ready = 1'b0;
  bit seen      = 1'b0;
  int m_x [TAPS];
  int m_c [TAPS];

  typedef struct {
    logic signed [OUT_W-1:0] val;
    bit                      has_lit;
    logic signed [OUT_W-1:0] lit;
    int                      t;
  } exp_t;
  exp_t q[$];

  fir_param_filter #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W), .SHIFT(SHIFT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic signed [OUT_W-1:0] reduce(input longint a);
    longint s;
    s = a >>> SHIFT;
`ifdef FIR_SATURATE_EN
    if (s > ((longint'(1) <<< (OUT_W-1)) - 1)) s = (longint'(1) <<< (OUT_W-1)) - 1;
    else if (s < -(longint'(1) <<< (OUT_W-1))) s = -(longint'(1) <<< (OUT_W-1));
`endif
    return s[OUT_W-1:0];
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < TAPS; i++) begin
      m_x[i] = 0;
      m_c[i] = 0;
    end
    m_c[0] = 1;
  endfunction

  // Inputs change 1 time unit after the rising edge; out_ready may be randomized.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    q.delete();
    model_reset();
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || !in_ready) && n < 300) begin
      tick();
      n++;
    end
    check("idle_reached", in_ready, 1);
  endtask

  task automatic write_coef(input int a, input int d);
    wait_idle();
    coef_we   = 1'b1;
    coef_addr = AW'(a);
    coef_data = COEF_W'(d);
    m_c[a]    = int'($signed(coef_data));
    tick();
    coef_we = 1'b0;
  endtask

  // Offer a sample (optionally with a coefficient write on the same edge) and
  // predict the result as the plain dot product of history and coefficients.
  task automatic send(input int v, input bit we, input int a, input int d,
                      input bit has_lit, input int lit);
    exp_t   e;
    longint acc;
    int     n = 0;
    in_valid  = 1'b1;
    in_data   = DATA_W'(v);
    coef_we   = we;
    coef_addr = AW'(a);
    coef_data = COEF_W'(d);
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    check("send_in_ready", in_ready, 1);
    if (we) m_c[a] = int'($signed(coef_data));
    for (int i = TAPS-1; i > 0; i--) m_x[i] = m_x[i-1];
    m_x[0] = int'($signed(in_data));
    acc = 0;
    for (int i = 0; i < TAPS; i++) acc += longint'(m_x[i]) * longint'(m_c[i]);
    e.val     = reduce(acc);
    e.has_lit = has_lit;
    e.lit     = OUT_W'(lit);
    e.t       = cyc + 1;
    q.push_back(e);
    tick();
    in_valid = 1'b0;
    coef_we  = 1'b0;
  endtask

  // Compare process: every cycle out_valid is high, check against the oldest prediction.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (q.size() == 0) begin
        check("spurious_out_valid", out_valid, 0);
      end else begin
        if (!seen) begin
          check("latency", cyc - q[0].t, TAPS + 1);
          seen = 1'b1;
        end
        check("model_out_data", out_data, q[0].val);
        if (q[0].has_lit) check("literal_out_data", out_data, q[0].lit);
        if (out_ready) begin
          void'(q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    int n;
    int highs;
    model_reset();
    apply_reset();

    // Identity filter passes samples straight through.
    send(5, 0, 0, 0, 1, 5);
    wait_idle();
    send(-3, 0, 0, 0, 1, -3);
    wait_idle();

    // Back-pressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    send(9, 0, 0, 0, 1, 9);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      check("hold_out_valid", out_valid, 1);
      check("hold_out_data", out_data, 9);
      check("hold_in_ready", in_ready, 0);
      check("hold_busy", busy, 1);
      tick();
    end
    out_ready = 1'b1;
    check("hold_still_valid", out_valid, 1);
    tick();
    check("hold_accepted", out_valid, 0);
    check("hold_back_idle", in_ready, 1);

    // Moving sum: all coefficients 1.
    apply_reset();
    for (int i = 0; i < TAPS; i++) write_coef(i, 1);
    send(1, 0, 0, 0, 1, 1);
    send(2, 0, 0, 0, 1, 3);
    send(3, 0, 0, 0, 1, 6);
    wait_idle();

    // Full-scale accumulation: 8 * 127 * 127 = 129032 exceeds OUT_W.
    apply_reset();
    for (int i = 0; i < TAPS; i++) write_coef(i, 127);
    for (int i = 0; i < TAPS; i++) send(127, 0, 0, 0, i == TAPS-1, BIG_RESULT);
    wait_idle();

    // Coefficient write on the transfer edge is used by that very sample: 3*5.
    apply_reset();
    send(3, 1, 0, 5, 1, 15);
    wait_idle();

    // Coefficient write during MAC is ignored.
    apply_reset();
    send(7, 0, 0, 0, 1, 7);
    tick();
    tick();
    coef_we   = 1'b1;
    coef_addr = '0;
    coef_data = COEF_W'(9);
    tick();
    coef_we = 1'b0;
    wait_idle();
    send(2, 0, 0, 0, 1, 2);
    wait_idle();

    // Reset mid-MAC aborts the result.
    send(6, 0, 0, 0, 0, 0);
    tick();
    tick();
    apply_reset();
    highs = 0;
    for (int i = 0; i < TAPS + 4; i++) begin
      if (out_valid) highs++;
      tick();
    end
    check("abort_no_output", highs, 0);
    send(4, 0, 0, 0, 1, 4);
    wait_idle();

    // Randomized traffic with random coefficients, writes and back-pressure.
    apply_reset();
    for (int i = 0; i < TAPS; i++) write_coef(i, int'($urandom_range(0, 255)));
    rnd_ready = 1'b1;
    for (int i = 0; i < 60; i++)
      send(int'($urandom_range(0, 255)), $urandom_range(0, 3) == 0,
           int'($urandom_range(0, TAPS-1)), int'($urandom_range(0, 255)), 0, 0);
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    check("drain_queue_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
